// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serializing per-thread LSU requests onto the single-ported synchronous scratchpad.
// Optional macro SMEM_ARB_BROADCAST_EN: one scratchpad read answers every thread reading the winner's address.
module shared_mem_arbiter #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int ADDR_BITS         = 8,
    parameter int DATA_BITS         = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [THREADS_PER_BLOCK-1:0]           req_valid,
    input  logic [THREADS_PER_BLOCK-1:0]           req_write,
    input  logic [THREADS_PER_BLOCK*ADDR_BITS-1:0] req_addr,
    input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] req_wdata,
    output logic [THREADS_PER_BLOCK-1:0]           resp_valid,
    output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] resp_rdata,
    output logic                                   mem_read_enable,
    output logic [ADDR_BITS-1:0]                   mem_read_addr,
    input  logic [DATA_BITS-1:0]                   mem_read_data,
    output logic                                   mem_write_enable,
    output logic [ADDR_BITS-1:0]                   mem_write_addr,
    output logic [DATA_BITS-1:0]                   mem_write_data
);
    localparam int T  = THREADS_PER_BLOCK;
    localparam int A  = ADDR_BITS;
    localparam int D  = DATA_BITS;
    localparam int PW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        r_state;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_grant;
    logic [T-1:0]  r_mask;
    logic [T-1:0]  r_resp_valid;
    logic          r_re;
    logic          r_we;
    logic [A-1:0]  r_rd_addr;
    logic [A-1:0]  r_wr_addr;
    logic [D-1:0]  r_wr_data;

    logic [PW-1:0] w_scan_idx [T];
    logic          w_found;
    logic [PW-1:0] w_winner;
    logic [A-1:0]  w_win_addr;
    logic [D-1:0]  w_win_wdata;
    logic          w_win_write;
    logic [T-1:0]  w_onehot;
    logic [T-1:0]  w_mask;

    genvar gi;
    generate
        for (gi = 0; gi < T; gi++) begin : g_lane
            logic [D-1:0] r_rdata;

            // Scan order starts at the round-robin pointer; T is a power of two so the add wraps.
            assign w_scan_idx[gi] = r_rr_ptr + PW'(gi);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rdata <= '0;
                end else if (r_state == WAIT && r_mask[gi]) begin
                    r_rdata <= mem_read_data;
                end
            end

            assign resp_rdata[gi*D +: D] = r_rdata;
        end
    endgenerate

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < T; k++) begin
            if (!w_found && req_valid[w_scan_idx[k]]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx[k];
            end
        end
    end

    assign w_win_addr  = req_addr[w_winner*A +: A];
    assign w_win_wdata = req_wdata[w_winner*D +: D];
    assign w_win_write = req_write[w_winner];
    assign w_onehot    = T'(1) << w_winner;

`ifdef SMEM_ARB_BROADCAST_EN
    logic [T-1:0] w_addr_match;

    generate
        for (gi = 0; gi < T; gi++) begin : g_match
            assign w_addr_match[gi] = (req_addr[gi*A +: A] == w_win_addr);
        end
    endgenerate

    // Writes are never merged; a read picks up every reader of the same address.
    assign w_mask = w_win_write ? w_onehot : (req_valid & ~req_write & w_addr_match);
`else
    assign w_mask = w_onehot;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_mask       <= '0;
            r_resp_valid <= '0;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_winner;
                        r_mask    <= w_mask;
                        r_rd_addr <= w_win_addr;
                        r_wr_addr <= w_win_addr;
                        r_wr_data <= w_win_wdata;
                        r_we      <= w_win_write;
                        r_re      <= ~w_win_write;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_we <= 1'b0;
                    r_re <= 1'b0;
                    // r_we is still high here exactly when the granted access is a write.
                    if (r_we) begin
                        r_resp_valid <= r_mask;
                        r_state      <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_resp_valid <= r_mask;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_rr_ptr <= r_grant + PW'(1);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid       = r_resp_valid;
    assign mem_read_enable  = r_re;
    assign mem_read_addr    = r_rd_addr;
    assign mem_write_enable = r_we;
    assign mem_write_addr   = r_wr_addr;
    assign mem_write_data   = r_wr_data;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: transaction-level timeline model plus directed literal checks.
// Honours SMEM_ARB_BROADCAST_EN when the design is built with it.
module tb_shared_mem_arbiter;
    localparam int T = 4;
    localparam int A = 8;
    localparam int D = 8;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic [T-1:0]   req_valid = '0;
    logic [T-1:0]   req_write = '0;
    logic [T*A-1:0] req_addr  = '0;
    logic [T*D-1:0] req_wdata = '0;
    logic [T-1:0]   resp_valid;
    logic [T*D-1:0] resp_rdata;
    logic           mem_read_enable;
    logic [A-1:0]   mem_read_addr;
    logic [D-1:0]   mem_read_data;
    logic           mem_write_enable;
    logic [A-1:0]   mem_write_addr;
    logic [D-1:0]   mem_write_data;

    shared_mem_arbiter #(
        .THREADS_PER_BLOCK(T),
        .ADDR_BITS        (A),
        .DATA_BITS        (D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .mem_read_enable (mem_read_enable),
        .mem_read_addr   (mem_read_addr),
        .mem_read_data   (mem_read_data),
        .mem_write_enable(mem_write_enable),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a * 8'd37 + 8'd11;
    endfunction

    // Scratchpad: synchronous write, one-cycle registered read, untouched while reset is high.
    bit [7:0]   sp_mem [256];
    bit [255:0] sp_wr;
    always @(posedge clk) begin
        if (reset !== 1'b1 && mem_write_enable === 1'b1) begin
            sp_mem[mem_write_addr] <= mem_write_data;
            sp_wr[mem_write_addr]  <= 1'b1;
        end
        if (mem_read_enable === 1'b1)
            mem_read_data <= sp_wr[mem_read_addr] ? sp_mem[mem_read_addr] : init_val(mem_read_addr);
    end

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } job_t;

    typedef struct {
        int             cyc;
        logic [T-1:0]   mask;
        int             lat;
        logic [T*D-1:0] data;
    } rsp_t;

    job_t         jq [T][$];
    logic [T-1:0] pend = '0;
    int           present_cyc [T];
    rsp_t         log_q [$];
    logic [T-1:0] seen;
    logic         last_re;
    logic [7:0]   last_waddr, last_wdata;
    int           re_cnt, we_cnt;
    int           cyc    = 0;
    bit           chk_en = 1'b0;
    int           n_chk  = 0;
    int           n_err  = 0;

    // Model: expected outputs for the current cycle plus a short timeline of scheduled events.
    bit [7:0]     ref_mem [256];
    bit           e_re, e_we;
    logic [7:0]   e_raddr, e_waddr, e_wdata;
    logic [T-1:0] e_resp;
    logic [7:0]   e_rd [T];
    int           rr, next_idle;
    bit           rg_we [8];
    bit           rg_re [8];
    bit           rg_ld [8];
    logic [7:0]   rg_addr [8];
    logic [7:0]   rg_wd [8];
    logic [7:0]   rg_rdv [8];
    logic [T-1:0] rg_resp [8];
    logic [T-1:0] rg_rdm [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic [T*D-1:0] ep;
        for (int i = 0; i < T; i++) ep[i*D +: D] = e_rd[i];
        chk("resp_valid", resp_valid, e_resp);
        chk("mem_read_enable", mem_read_enable, e_re);
        chk("mem_write_enable", mem_write_enable, e_we);
        chk("mem_read_addr", mem_read_addr, e_raddr);
        chk("mem_write_addr", mem_write_addr, e_waddr);
        chk("mem_write_data", mem_write_data, e_wdata);
        chk("resp_rdata", resp_rdata, ep);
    endtask

    task automatic clear_slot(input int s);
        rg_we[s] = 0; rg_re[s] = 0; rg_ld[s] = 0;
        rg_resp[s] = '0; rg_rdm[s] = '0;
    endtask

    // Computes what every output must be in the next cycle from this cycle's inputs.
    task automatic model_next();
        int n, w, m1, t;
        logic [7:0] wa, wd;
        logic [T-1:0] mask;
        n = (cyc + 1) % 8;
        e_re = 0; e_we = 0; e_resp = '0;
        if (reset === 1'b1) begin
            for (int s = 0; s < 8; s++) clear_slot(s);
            e_raddr = '0; e_waddr = '0; e_wdata = '0;
            for (int i = 0; i < T; i++) e_rd[i] = '0;
            rr = 0;
            next_idle = cyc + 1;
        end else begin
            if (cyc >= next_idle && req_valid != '0) begin
                w = -1;
                for (int k = 0; k < T; k++) begin
                    t = (rr + k) % T;
                    if (w < 0 && req_valid[t]) w = t;
                end
                wa = req_addr[w*A +: A];
                wd = req_wdata[w*D +: D];
                m1 = (cyc + 1) % 8;
                rg_ld[m1] = 1; rg_addr[m1] = wa; rg_wd[m1] = wd;
                mask = T'(1) << w;
                if (req_write[w]) begin
                    rg_we[m1] = 1;
                    rg_resp[(cyc + 2) % 8] = mask;
                    ref_mem[wa] = wd;
                    next_idle = cyc + 3;
                end else begin
`ifdef SMEM_ARB_BROADCAST_EN
                    for (int i = 0; i < T; i++)
                        if (req_valid[i] && !req_write[i] && req_addr[i*A +: A] == wa) mask[i] = 1'b1;
`endif
                    rg_re[m1] = 1;
                    rg_resp[(cyc + 3) % 8] = mask;
                    rg_rdm[(cyc + 3) % 8]  = mask;
                    rg_rdv[(cyc + 3) % 8]  = ref_mem[wa];
                    next_idle = cyc + 4;
                end
                rr = (w + 1) % T;
            end
            e_we = rg_we[n];
            e_re = rg_re[n];
            if (rg_ld[n]) begin
                e_raddr = rg_addr[n]; e_waddr = rg_addr[n]; e_wdata = rg_wd[n];
            end
            e_resp = rg_resp[n];
            for (int i = 0; i < T; i++) if (rg_rdm[n][i]) e_rd[i] = rg_rdv[n];
            clear_slot(n);
        end
    endtask

    task automatic sample();
        rsp_t r;
        int f;
        seen = resp_valid;
        last_re = mem_read_enable;
        if (!chk_en) return;
        if (mem_read_enable === 1'b1) re_cnt++;
        if (mem_write_enable === 1'b1) begin
            we_cnt++;
            last_waddr = mem_write_addr;
            last_wdata = mem_write_data;
        end
        if (resp_valid != '0) begin
            f = 0;
            for (int i = T - 1; i >= 0; i--) if (resp_valid[i]) f = i;
            r.cyc = cyc; r.mask = resp_valid; r.lat = cyc - present_cyc[f]; r.data = resp_rdata;
            log_q.push_back(r);
            $display("txn cycle=%0d threads=%b rdata=%h latency=%0d", cyc, resp_valid, resp_rdata, r.lat);
        end
    endtask

    task automatic drive();
        job_t j;
        for (int i = 0; i < T; i++) begin
            if (pend[i] && seen[i] === 1'b1) begin
                pend[i] = 1'b0;
                void'(jq[i].pop_front());
            end
            if (!pend[i] && jq[i].size() > 0) begin
                j = jq[i][0];
                req_write[i]         = j.wr;
                req_addr[i*A +: A]   = j.addr;
                req_wdata[i*D +: D]  = j.data;
                pend[i]              = 1'b1;
                present_cyc[i]       = cyc;
            end
            req_valid[i] = pend[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) compare();
        sample();
        model_next();
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < T; i++) jq[i].delete();
        pend = '0;
        req_valid = '0;
    endtask

    function automatic bit busy();
        bit b = (pend != '0);
        for (int i = 0; i < T; i++) if (jq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic clear_logs();
        log_q.delete();
        re_cnt = 0;
        we_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (busy() && k < max_cycles) begin
            step();
            k++;
        end
        chk("drain_done", busy(), 0);
        step();
    endtask

    task automatic push(input int t, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        job_t j;
        j.wr = wr; j.addr = addr; j.data = data;
        jq[t].push_back(j);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(8'(a));

        // Idle after reset: nothing may move.
        do_reset();
        for (int k = 0; k < 10; k++) step();
        chk("idle_quiet", re_cnt + we_cnt + log_q.size(), 0);
        chk("idle_resp_valid", resp_valid, 0);

        // Thread 0 writes then reads back.
        clear_logs();
        push(0, 1'b1, 8'h10, 8'hA5);
        push(0, 1'b0, 8'h10, 8'h00);
        drain(60);
        chk("t1_write_pulses", we_cnt, 1);
        chk("t1_write_addr", last_waddr, 8'h10);
        chk("t1_write_data", last_wdata, 8'hA5);
        chk("t1_responses", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_wr_mask", log_q[0].mask, 4'b0001);
            chk("t1_wr_latency", log_q[0].lat, 2);
            chk("t1_rd_latency", log_q[1].lat, 3);
            chk("t1_rd_data", log_q[1].data[7:0], 8'hA5);
        end

        // Four simultaneous reads of distinct addresses.
        do_reset();
        for (int i = 0; i < T; i++) push(i, 1'b0, 8'(8'h40 + i), 8'h00);
        drain(80);
        chk("t2_responses", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < T; i++) begin
                chk("t2_order", log_q[i].mask, T'(1) << i);
                chk("t2_lane_data", log_q[i].data[i*D +: D], init_val(8'(8'h40 + i)));
                if (i > 0) chk("t2_spacing", log_q[i].cyc - log_q[i-1].cyc, 4);
            end
            chk("t2_first_latency", log_q[0].lat, 3);
        end

        // Threads 1 and 3 contend continuously.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(1, 1'b0, 8'(8'h50 + k), 8'h00);
            push(3, 1'b0, 8'(8'h60 + k), 8'h00);
        end
        drain(100);
        chk("t3_responses", log_q.size(), 6);
        if (log_q.size() == 6)
            for (int k = 0; k < 6; k++) chk("t3_rr_order", log_q[k].mask, (k % 2 == 0) ? 4'b0010 : 4'b1000);

        // Reset while thread 2's read sits in WAIT.
        do_reset();
        push(2, 1'b0, 8'h30, 8'h00);
        for (int k = 0; k < 20 && last_re !== 1'b1; k++) step();
        chk("t4_issue_seen", last_re, 1);
        reset = 1'b1;
        flush();
        step();
        reset = 1'b0;
        step();
        chk("t4_resp_valid_zero", resp_valid, 0);
        chk("t4_enables_zero", {mem_read_enable, mem_write_enable}, 0);
        chk("t4_rdata_zero", resp_rdata, 0);
        chk("t4_addr_zero", {mem_read_addr, mem_write_addr, mem_write_data}, 0);
        for (int k = 0; k < 8; k++) step();
        chk("t4_no_response", log_q.size(), 0);

        // Four readers of one address.
        do_reset();
        push(0, 1'b1, 8'h20, 8'h3C);
        drain(40);
        clear_logs();
        for (int i = 0; i < T; i++) push(i, 1'b0, 8'h20, 8'h00);
        drain(80);
`ifdef SMEM_ARB_BROADCAST_EN
        chk("t5_read_pulses", re_cnt, 1);
        chk("t5_responses", log_q.size(), 1);
        if (log_q.size() == 1) chk("t5_mask", log_q[0].mask, 4'b1111);
`else
        chk("t5_read_pulses", re_cnt, 4);
        chk("t5_responses", log_q.size(), 4);
`endif
        for (int i = 0; i < T; i++) chk("t5_lane_data", resp_rdata[i*D +: D], 8'h3C);

        // Random traffic on a small address window so reads and writes collide.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < T; i++)
                if (jq[i].size() < 2 && $urandom_range(0, 5) == 0)
                    push(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
            step();
        end
        drain(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Serializes per-thread shared-memory requests from the block's THREADS_PER_BLOCK thread LSUs onto the single-ported, synchronous block scratchpad. It sits directly upstream of the scratchpad and drives its read and write ports. It uses a round-robin grant and returns a one-cycle response pulse with read data to the granted thread. It also absorbs the scratchpad's one-cycle read latency.

## Interface
- THREADS_PER_BLOCK, 4, number of requesting threads (T)
- ADDR_BITS, 8, scratchpad address width (A)
- DATA_BITS, 8, data width (D)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  T  per-thread request; held high until that thread's resp_valid
- req_write  in  T  1 = write, 0 = read; stable while req_valid
- req_addr  in  T*A  packed addresses; thread i at [i*A +: A]
- req_wdata  in  T*D  packed write data; thread i at [i*D +: D]
- resp_valid  out  T  one-cycle completion pulse per thread
- resp_rdata  out  T*D  packed read data; valid with resp_valid, held until next response to that thread
- mem_read_enable  out  1  to scratchpad read_enable
- mem_read_addr  out  A  to scratchpad read_addr
- mem_read_data  in  D  from scratchpad read_data; valid the cycle after read_enable
- mem_write_enable  out  1  to scratchpad write_enable
- mem_write_addr  out  A  to scratchpad write_addr
- mem_write_data  out  D  to scratchpad write_data

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.

- **IDLE**
  - Scan req_valid starting at rr_ptr, ascending, wrapping modulo T. The first set bit wins and is stored in `grant`.
  - Load the memory address and data registers from the winner.
  - Set mem_write_enable = req_write[grant]. Set mem_read_enable = ~req_write[grant].
  - Go to ISSUE.
  - With no request, stay in IDLE with both enables 0.
- **ISSUE**
  - The enable is high for exactly this cycle. Clear it at the end of the cycle.
  - Write: go to DONE.
  - Read: go to WAIT.
- **WAIT**
  - Capture mem_read_data into resp_rdata[grant].
  - Go to DONE.
- **DONE**
  - resp_valid[grant] = 1 for this cycle only.
  - Set rr_ptr = (grant + 1) mod T.
  - Go to IDLE.
- Reads and writes have equal priority. There is no reordering within a thread; each thread has at most one outstanding request.
- Address and data registers hold their last value while both enables are 0.
- Requester rule: drop req_valid (or present a new request) in the cycle after it samples resp_valid. The arbiter never re-grants the same request, because IDLE follows DONE.
- rr_ptr wraps from T-1 to 0. T must be a power of two; the pointer is log2(T) bits.
- A write and a later read to the same address from different threads are ordered by grant. The read returns the new data.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, grant = 0
  - resp_valid = 0, resp_rdata = 0
  - all mem_* outputs = 0
- Reset mid-operation aborts the transaction: no resp_valid is produced. Any write already in ISSUE at the reset edge is discarded, because the scratchpad resets too.
- Latency is measured from the IDLE cycle in which the request is seen to the resp_valid cycle:
  - write: 3 cycles (IDLE, ISSUE, DONE)
  - read: 4 cycles (IDLE, ISSUE, WAIT, DONE)
- Maximum throughput is one write per 3 cycles, or one read per 4 cycles.
- A request that is asserted in a non-IDLE state waits for the next IDLE.
- Worst-case wait for any thread is T-1 other transactions. There is no starvation.

## Configuration
- Macro: SMEM_ARB_BROADCAST_EN.
- Defined:
  - When a read is granted, latch mask = req_valid & ~req_write & (req_addr[i] == winner address).
  - In WAIT, write mem_read_data to resp_rdata of every masked thread.
  - In DONE, pulse resp_valid for all masked threads simultaneously.
  - rr_ptr still advances to grant + 1.
  - Writes are never merged.
- Undefined: exactly one thread is served per transaction, as described above.

## Test plan
- Reset with all req_valid = 0 → all outputs 0 and no enables, ever.
- Thread 0 writes 0xA5 to address 0x10, then reads 0x10:
  - write: mem_write_enable high exactly one cycle, addr 0x10, data 0xA5; resp_valid[0] 3 cycles after request.
  - read: resp_rdata[0] = 0xA5 with resp_valid[0] 4 cycles after request.
- All 4 threads request reads of distinct addresses at once → grants in order 0, 1, 2, 3. One resp_valid every 4 cycles; each thread gets its own data.
- Round-robin check: threads 1 and 3 request continuously (reissuing after each response), rr_ptr = 0 → grant order 1, 3, 1, 3, ...
- Reset asserted during WAIT of a read by thread 2 → no resp_valid[2]; state IDLE next cycle; all outputs 0.
- With SMEM_ARB_BROADCAST_EN, threads 0–3 all read address 0x20 (value 0x3C) → one mem_read_enable pulse; resp_valid = 4'b1111 in a single cycle; every resp_rdata lane = 0x3C. Without the macro → four separate transactions.
